// File: rtl/mult_sched_pkg.sv
// Shared state encoding and elaboration helpers for the shared-multiplier scheduler.
package mult_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SETTLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    // Never returns less than 1 so single-value ranges still get a real bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mult_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, with wrap.
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Walk from the farthest offset down so the nearest request overwrites.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = ID_W'(j);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler time-sharing one external signed array multiplier between
// NUM_REQ requesters; sequences the start pulse, waits SETTLE_CYC, returns a tagged product.
module mult_share_sched
    import mult_sched_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int NUM_REQ    = 4,
    parameter  int SETTLE_CYC = 2,
    localparam int ID_W       = clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [2*WIDTH-1:0]       rsp_product,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_multiplicand,
    output logic [WIDTH-1:0]         mul_multiplier,
    input  logic [2*WIDTH-1:0]       mul_product,
    output logic                     busy
);

    localparam int CNT_W = clog2(SETTLE_CYC);

    state_e               state_q;
    logic [ID_W-1:0]      rr_ptr_q;
    logic [ID_W-1:0]      rr_ptr_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [ID_W-1:0]      id_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic                 start_q;
    logic                 rsp_valid_q;
    logic                 busy_q;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [ID_W-1:0]      win_idx;
    logic                 arb_any;
    logic                 grant_window;
    logic                 take_d;
    logic [WIDTH-1:0]     win_a;
    logic [WIDTH-1:0]     win_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (win_idx),
        .any (arb_any)
    );

    // Grants happen from IDLE, or from DONE in the very cycle the response is consumed.
    assign grant_window = (state_q == S_IDLE) || ((state_q == S_DONE) && rsp_ready);
    assign take_d       = grant_window && arb_any && !rst;
    assign req_ready    = take_d ? arb_gnt : '0;
    assign rr_ptr_d     = (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    assign win_a        = req_a[win_idx*WIDTH +: WIDTH];
    assign win_b        = req_b[win_idx*WIDTH +: WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            prod_q      <= '0;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                end
                S_LOAD: begin
                    state_q <= S_SETTLE;
                    start_q <= 1'b0;
                    cnt_q   <= '0;
                end
                S_SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                        prod_q      <= mul_product;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // A grant overrides the IDLE fall-through taken above on a DONE handshake.
            if (take_d) begin
                a_q      <= win_a;
                b_q      <= win_b;
                id_q     <= win_idx;
                rr_ptr_q <= rr_ptr_d;
                start_q  <= 1'b1;
                busy_q   <= 1'b1;
                state_q  <= S_LOAD;
            end
        end
    end

    assign mul_start        = start_q;
    assign mul_multiplicand = a_q;
    assign mul_multiplier   = b_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_id           = id_q;
    assign rsp_product      = prod_q;
    assign busy             = busy_q;

endmodule
